// File: rtl/median_stream_finder.sv
// median_stream_finder: streams N unsigned samples into an insertion-sorted register array
// and holds median/min/max of the set until the consumer accepts.
module median_stream_finder #(
  parameter int DATA_W = 4,
  parameter int N      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_median,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max
);
  localparam int CW  = $clog2(N + 1);
  localparam int MID = (N - 1) / 2;
  typedef enum logic {FILL, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_sort [N];
  logic [DATA_W-1:0] w_ins  [N];
  logic [N-1:0]      w_keep;
  logic              w_acc, w_last;
  assign in_ready  = r_state == FILL;
  assign out_valid = r_state == DONE;
  assign w_acc     = in_valid && in_ready;
  assign w_last    = w_acc && r_count == CW'(N - 1);
  // Occupied entries <= sample stay put; the first larger one takes the sample and the rest shift up.
  for (genvar i = 0; i < N; i++) begin : g_ins
    assign w_keep[i] = CW'(i) < r_count && r_sort[i] <= in_data;
    if (i == 0) begin : g_lo
      assign w_ins[i] = w_keep[i] ? r_sort[i] : in_data;
    end else begin : g_hi
      assign w_ins[i] = w_keep[i] ? r_sort[i] :
                        (CW'(i - 1) < r_count && !w_keep[i-1]) ? r_sort[i-1] : in_data;
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == FILL && w_last) w_next = DONE;
    if (r_state == DONE && out_ready) w_next = FILL;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      out_median <= '0;
      out_min    <= '0;
      out_max    <= '0;
      for (int k = 0; k < N; k++) r_sort[k] <= '0;
    end else if (w_acc) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
      for (int k = 0; k < N; k++) r_sort[k] <= w_ins[k];
      if (w_last) begin
        out_median <= w_ins[MID];
        out_min    <= w_ins[0];
        out_max    <= w_ins[N-1];
      end
    end
  end
endmodule

// File: doc/median_stream_finder.md
# median_stream_finder

Sequential median finder that takes a serial stream of unsigned samples, one per valid/ready handshake, and keeps them in an insertion-sorted register array. After N samples it presents the median, min and max of the set and holds them until the consumer accepts. It extends the combinational 3-input median block to a stream-fed, parameter-sized window for upstream sources that deliver one number per cycle.

## Interface
- DATA_W, 4, sample width in bits, unsigned
- N, 5, set size; odd, 3..15
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  DATA_W  sample value
- out_valid  output  1  result set is valid
- out_ready  input  1  consumer accepts the result this cycle
- out_median  output  DATA_W  element (N-1)/2 of the ascending-sorted set
- out_min  output  DATA_W  smallest element of the set
- out_max  output  DATA_W  largest element of the set

## Operation
- States:
  - FILL: collecting samples; count runs 0..N-1.
  - DONE: result held.
- Reset: state=FILL, count=0, all sort registers 0, out_valid=0, out_median=out_min=out_max=0.
- in_ready = (state==FILL). It is a function of state only and never depends on in_valid.
- Accept condition: in_valid && in_ready at the clock edge.
- On accept in FILL, in_data is inserted into sort[0..count] in ascending order:
  - sort[i] with sort[i] <= in_data stays in place.
  - The first position with sort[i] > in_data takes in_data, and all higher occupied entries shift up by one.
  - Ties: a new sample goes after existing equal values. Only the stability of the ordering is affected; output values are not.
  - Only entries below count are meaningful. Entries at or above count are don't-care and are not compared.
- count increments on each accept. On the accept that makes count reach N: state goes to DONE, count clears to 0, and out_valid is set the next cycle.
- In DONE:
  - out_median=sort[(N-1)/2], out_min=sort[0], out_max=sort[N-1].
  - Outputs and the sort array are frozen; in_data and in_valid are ignored.
- On out_valid && out_ready: state goes to FILL and out_valid drops the next cycle. out_* keep their last values until the next DONE; the verifier checks them only while out_valid=1.
- No arithmetic is performed. All comparisons are unsigned DATA_W-bit magnitude compares, with no width growth.
- When rst is asserted mid-set or while in DONE, any partial or pending result is discarded and the block returns to the reset values listed above.

## Timing
- Insertion is a single-cycle operation: a sample accepted at edge k is in sorted position after edge k.
- Throughput in FILL is one sample per cycle when in_valid is held high.
- Latency: out_valid rises on the edge of the Nth accept and is visible in the cycle following the Nth handshake.
- Minimum period per set is N+1 cycles: N accept cycles plus one DONE cycle with out_ready=1.
- Reset: in the cycle after rst is sampled high, all outputs hold reset values and in_ready=1. If rst and in_valid are both high in the same cycle, reset wins and the sample is not accepted.
- Output backpressure: if out_ready stays low, out_valid and the out_* values stay stable indefinitely and in_ready stays 0.
- Simultaneous events: an in_valid during DONE, even in the same cycle as out_ready, is not accepted. The first sample of the next set can be accepted no earlier than the cycle after the out handshake.

## Test plan
- N=5, DATA_W=4, samples 9,2,7,4,15 back-to-back -> out_valid one cycle after the 5th handshake, median=7, min=2, max=15; in_ready=0 while out_valid=1.
- Duplicates 3,3,3,1,3 -> median=3, min=1, max=3; all-equal 0,0,0,0,0 -> median=0, min=0, max=0. Boundary values 15,0,15,0,8 -> median=8, min=0, max=15.
- Gapped in_valid (samples 5,1,9,6,2 with idle cycles between) plus out_ready held low for 10 cycles -> median=5, min=1, max=9. Outputs stable throughout the stall; in_valid pulses during the stall are ignored.
- Back-to-back sets: {1,2,3,4,5} then {10,14,12,11,13} with out_ready=1 -> medians 3 then 12. Second set's first accept occurs one cycle after the first result handshake; total 12 cycles.
- rst asserted after 3 accepted samples (8,8,8), then set 4,1,6,2,0 -> out_valid stays 0 before the new 5th sample, median=2, min=0, max=6. rst asserted during DONE -> out_valid drops next cycle, in_ready=1.
- N=3 build, random 4-bit triples (≥1000) -> out_median equals the combinational median of each triple; N=15, random sets -> equals the software sort median.
